// File: rtl/n_squared_pkg.sv
// Shared constants and helpers for the n-squared counter.
// Build option: N_SQUARED_CHECK_EN enables a simulation-only self-check in the top.
package n_squared_pkg;

  // Default width W of the internal count n.
  localparam int N_SQ_DEFAULT_WIDTH = 4;

  // Width of the running square for a count of width w.
  function automatic int sq_width(input int w);
    return 2 * w;
  endfunction

endpackage : n_squared_pkg

// File: rtl/square_step.sv
// One step of the incremental square: (n+1)^2 = n^2 + 2n + 1.
// Purely combinational; the caller owns the registers.
module square_step
  import n_squared_pkg::*;
#(
  parameter int W = N_SQ_DEFAULT_WIDTH
) (
  input  logic [W-1:0]           n,
  input  logic [sq_width(W)-1:0] sq,
  output logic [W-1:0]           n_next,
  output logic [sq_width(W)-1:0] sq_next
);

  localparam int SW = sq_width(W);

  // 2n+1 as a (W+1)-bit value is simply n with a 1 appended below it.
  logic [W:0]    odd_inc;
  logic [SW-1:0] odd_ext;

  // Zero-extend the odd increment; assigning a slice avoids a zero-width
  // replication when W=1.
  always_comb begin
    odd_inc      = {n, 1'b1};
    odd_ext      = '0;
    odd_ext[W:0] = odd_inc;
  end

  // Both sums truncate naturally, which makes the wrap at n=2^W-1 land on 0.
  assign n_next  = n + 1'b1;
  assign sq_next = sq + odd_ext;

endmodule : square_step

// File: rtl/n_squared_counter.sv
// Free-running counter whose output is n^2, built without a multiplier.
// Build option: N_SQUARED_CHECK_EN adds a simulation-only comparison of the
// output against a true multiply; the synthesized logic is unchanged.
module n_squared_counter
  import n_squared_pkg::*;
#(
  parameter int count_width = N_SQ_DEFAULT_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic [sq_width(count_width)-1:0] count_squared
);

  localparam int W  = count_width;
  localparam int SW = sq_width(count_width);

  logic [W-1:0]  n_q,  n_d;
  logic [SW-1:0] sq_q, sq_d;

  square_step #(.W(W)) u_step (
    .n       (n_q),
    .sq      (sq_q),
    .n_next  (n_d),
    .sq_next (sq_d)
  );

  // State registers: cleared immediately by reset, advanced every edge otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_q  <= '0;
      sq_q <= '0;
    end else begin
      n_q  <= n_d;
      sq_q <= sq_d;
    end
  end

  assign count_squared = sq_q;

`ifdef N_SQUARED_CHECK_EN
  logic [SW-1:0] sq_ref;
  assign sq_ref = SW'(SW'(n_q) * SW'(n_q));

  // Each cycle out of reset, compare the running square against n*n.
  always @(posedge clk) begin
    if (reset && (count_squared !== sq_ref))
      $error("n_squared_counter: n=%0d expected=%0d actual=%0d", n_q, sq_ref, count_squared);
  end
`endif

endmodule : n_squared_counter

// File: tb/tb_n_squared_counter.sv
// Directed bench for n_squared_counter at widths 4, 1 and 8.
module tb_n_squared_counter;

  logic        clk;
  logic        reset;
  logic [7:0]  sq4;
  logic [1:0]  sq1;
  logic [15:0] sq8;

  int checks   = 0;
  int failures = 0;
  int edges    = 0;

  n_squared_counter #(.count_width(4)) dut4 (.clk(clk), .reset(reset), .count_squared(sq4));
  n_squared_counter #(.count_width(1)) dut1 (.clk(clk), .reset(reset), .count_squared(sq1));
  n_squared_counter #(.count_width(8)) dut8 (.clk(clk), .reset(reset), .count_squared(sq8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected square after e edges out of reset for width w.
  function automatic logic [15:0] exp_sq(input int e, input int w);
    int n;
    n = e % (1 << w);
    return 16'(n * n);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) edges++;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_w4"}, 16'(sq4), exp_sq(edges, 4));
    check({tag, "_w1"}, 16'(sq1), exp_sq(edges, 1));
    check({tag, "_w8"}, sq8,      exp_sq(edges, 8));
  endtask

  initial begin
    reset = 1'b0;
    #2;
    // Held in reset: output stays 0 across edges.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_hold_w4", 16'(sq4), 16'd0);
      check("reset_hold_w1", 16'(sq1), 16'd0);
      check("reset_hold_w8", sq8, 16'd0);
    end

    // Release between edges; first edges give 1,4,9,16.
    reset = 1'b1;
    edges = 0;
    tick(); check("edge1_w4", 16'(sq4), 16'd1);  check("edge1_w1", 16'(sq1), 16'd1);
    tick(); check("edge2_w4", 16'(sq4), 16'd4);  check("edge2_w1", 16'(sq1), 16'd0);
    tick(); check("edge3_w4", 16'(sq4), 16'd9);  check("edge3_w1", 16'(sq1), 16'd1);
    tick(); check("edge4_w4", 16'(sq4), 16'd16); check("edge4_w1", 16'(sq1), 16'd0);
    check("edge4_w8", sq8, 16'd16);

    while (edges < 15) begin tick(); check_all("run"); end
    check("edge15_w4", 16'(sq4), 16'd225);
    tick(); check("edge16_wrap_w4", 16'(sq4), 16'd0); check("edge16_w8", sq8, 16'd256);
    tick(); check("edge17_w4", 16'(sq4), 16'd1);

    while (edges < 255) begin tick(); check_all("run"); end
    check("edge255_w8", sq8, 16'd65025);
    tick(); check("edge256_wrap_w8", sq8, 16'd0); check("edge256_w4", 16'(sq4), 16'd0);

    // Restart from reset and count up to a value of 100 on the 4-bit counter.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    edges = 0;
    for (int i = 0; i < 10; i++) tick();
    check("pre_async_w4", 16'(sq4), 16'd100);
    // Asynchronous assertion mid-cycle: output drops before the next edge.
    #2;
    reset = 1'b0;
    #1;
    check("async_clear_w4", 16'(sq4), 16'd0);
    check("async_clear_w8", sq8, 16'd0);
    // Reset low across an edge keeps everything at 0.
    tick();
    check("reset_over_edge_w4", 16'(sq4), 16'd0);
    reset = 1'b1;
    edges = 0;
    tick(); check("restart1_w4", 16'(sq4), 16'd1);
    tick(); check("restart2_w4", 16'(sq4), 16'd4);

    // Free-run 600 ns at 10 ns clock, every sample equals n^2.
    for (int i = 0; i < 60; i++) begin tick(); check_all("freerun"); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_n_squared_counter
